pwm_ramp_sequencer: RTL
=======================

// Module: pwm_ramp_sequencer
// PURPOSE
//  Sequences the duty input of the 12-bit PWM generator. Accepts a target
//  duty per command and slews toward it, at most one step per PWM period.
//  Provides soft-start/soft-stop for DAC/LED loads on the DC2197 path.
//  Updates only on the PWM rollover pulse, so every period sees one stable duty.
// PARAMETERS
//  WIDTH    12  duty/counter width; must match the PWM generator
//  STEP_W    8  width of the per-period step size
//  DWELL_W   8  width of the dwell count (extra periods held between steps)
// PORTS
//  clk_in      in   1        system clock, same domain as the PWM generator
//  reset       in   1        synchronous, active-high reset
//  pwm_wrap    in   1        1-cycle pulse when the PWM counter rolls over to 0
//  cmd_valid   in   1        command request
//  cmd_ready   out  1        high when the block can accept a command (IDLE)
//  cmd_target  in   WIDTH    target duty
//  cmd_step    in   STEP_W   duty increment per step; 0 is treated as 1
//  cmd_dwell   in   DWELL_W  number of wraps to skip between steps
//  abort       in   1        stops a ramp in progress and freezes duty
//  duty        out  WIDTH    registered duty; drives the PWM duty input
//  busy        out  1        high while in RAMP
//  done        out  1        1-cycle pulse when duty reaches target
// BEHAVIOUR
//  Reset values: duty=0, busy=0, done=0, cmd_ready=1, state=IDLE, and all
//   internal registers cleared. Reset mid-ramp forces duty=0 on the next edge.
//  States: IDLE, RAMP. cmd_ready = (state==IDLE). busy = (state==RAMP).
//  Accept: cmd_valid&&cmd_ready at an edge. The block latches target, step
//   (0->1) and dwell, and loads dwell_cnt=cmd_dwell.
//   If target==duty, it stays in IDLE and pulses done on the next cycle.
//   Otherwise it enters RAMP.
//  RAMP, on each pwm_wrap:
//   dwell_cnt!=0 -> dwell_cnt--. Duty is unchanged.
//   dwell_cnt==0 -> apply a step and reload dwell_cnt=dwell.
//  Step: diff = |target-duty|, computed at WIDTH+1 bits.
//   diff<=step -> duty=target, done=1 for 1 cycle, next state IDLE.
//   else -> duty = duty+step (rising) or duty-step (falling).
//   Duty never overshoots the target and never wraps past 0 or 2^WIDTH-1.
//  Latency: with dwell D, the first step lands on the (D+1)th wrap after
//   accept. Duty updates on the edge that samples pwm_wrap=1.
//  Without pwm_wrap, RAMP holds indefinitely. No timeout.
//  abort in RAMP -> IDLE on the next edge. Duty holds its current value and
//   done is not pulsed. abort in IDLE is ignored.
//  abort and pwm_wrap on the same cycle: abort wins and no step is applied.
//  reset has priority over abort, pwm_wrap and cmd_valid.
//  cmd_valid while busy: not accepted and not queued. Requesters hold until
//   cmd_ready is high.
//  done and cmd_ready are high together. A new command is accepted in the same
//   cycle that done is asserted.
//  pwm_wrap in IDLE: no effect.
// TESTING
//  1 Ramp up: duty=0, target=100, step=25, dwell=0; wraps every 16 clk
//    -> duty 25,50,75,100 on successive wraps; done with 100; busy low after.
//  2 Clamp down: from 100, target=10, step=40 -> 60,20,10; done on the 3rd
//    wrap; no underflow.
//  3 Dwell: 0->30, step=10, dwell=2 -> duty changes only on wraps 3,6,9;
//    done on wrap 9.
//  4 Abort: ramp 0->200 step 50; abort after duty=100 -> duty stays 100,
//    cmd_ready=1, no done; abort coincident with a wrap -> no step.
//  5 Edges: step=0 behaves as 1; 4000->4095 step 255 -> 4095 in one wrap;
//    target==duty -> done 1 cycle after accept with no wrap needed.
//  6 Reset mid-ramp at duty=75 -> duty=0, IDLE, cmd_ready=1 next cycle;
//    cmd_valid while busy is never accepted.

Source files
------------

// File: rtl/pwm_ramp_sequencer.sv
// Slews the PWM duty toward a commanded target, at most one step per PWM period,
// with an optional dwell of whole periods between steps.
module pwm_ramp_sequencer #(
  parameter int WIDTH   = 12,
  parameter int STEP_W  = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               pwm_wrap,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_target,
  input  logic [STEP_W-1:0]  cmd_step,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               abort,
  output logic [WIDTH-1:0]   duty,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_duty;
  logic [WIDTH-1:0]   r_target;
  logic [STEP_W-1:0]  r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic               r_done;

  state_t             w_state_next;
  logic [WIDTH-1:0]   w_duty_next;
  logic [WIDTH-1:0]   w_target_next;
  logic [STEP_W-1:0]  w_step_next;
  logic [DWELL_W-1:0] w_dwell_next;
  logic [DWELL_W-1:0] w_dwell_cnt_next;
  logic               w_done_next;

  logic               w_rising;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_step_w;
  logic [WIDTH:0]     w_step_ext;

  // Distance to target is taken one bit wider so the subtraction cannot wrap.
  assign w_rising   = (r_target > r_duty);
  assign w_diff     = w_rising ? ({1'b0, r_target} - {1'b0, r_duty})
                               : ({1'b0, r_duty} - {1'b0, r_target});
  assign w_step_w   = WIDTH'(r_step);
  assign w_step_ext = {1'b0, w_step_w};

  always_comb begin
    w_state_next     = r_state;
    w_duty_next      = r_duty;
    w_target_next    = r_target;
    w_step_next      = r_step;
    w_dwell_next     = r_dwell;
    w_dwell_cnt_next = r_dwell_cnt;
    w_done_next      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_target_next    = cmd_target;
          w_step_next      = (cmd_step == '0) ? STEP_W'(1) : cmd_step;
          w_dwell_next     = cmd_dwell;
          w_dwell_cnt_next = cmd_dwell;
          if (cmd_target == r_duty) begin
            w_done_next = 1'b1;
          end else begin
            w_state_next = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (pwm_wrap) begin
          if (r_dwell_cnt != '0) begin
            w_dwell_cnt_next = r_dwell_cnt - DWELL_W'(1);
          end else begin
            w_dwell_cnt_next = r_dwell;
            // Final step clamps to target so duty never overshoots or wraps.
            if (w_diff <= w_step_ext) begin
              w_duty_next  = r_target;
              w_done_next  = 1'b1;
              w_state_next = ST_IDLE;
            end else if (w_rising) begin
              w_duty_next = r_duty + w_step_w;
            end else begin
              w_duty_next = r_duty - w_step_w;
            end
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_duty      <= '0;
      r_target    <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
      r_dwell_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_duty      <= w_duty_next;
      r_target    <= w_target_next;
      r_step      <= w_step_next;
      r_dwell     <= w_dwell_next;
      r_dwell_cnt <= w_dwell_cnt_next;
      r_done      <= w_done_next;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RAMP);
  assign duty      = r_duty;
  assign done      = r_done;

endmodule
